// File: rtl/sd_cmd_sequencer_if.sv
// SD command-line sequencer bus: request/argument inputs, CMD line pins,
// and the status/response outputs of the last command.
interface sd_cmd_sequencer_if;
  logic        sd_tick;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [1:0]  resp_type;
  logic        cmd_in;
  logic        cmd_out;
  logic        cmd_oe;
  logic        busy;
  logic        done;
  logic [5:0]  resp_index;
  logic [31:0] resp_data;
  logic        err_timeout;
  logic        err_crc;
  logic        err_index;
  logic        err_frame;

  // Host side: issues commands and drives the sampled CMD line level.
  modport master (
    output sd_tick, cmd_start, cmd_index, cmd_arg, resp_type, cmd_in,
    input  cmd_out, cmd_oe, busy, done, resp_index, resp_data,
    input  err_timeout, err_crc, err_index, err_frame
  );

  // Sequencer side.
  modport slave (
    input  sd_tick, cmd_start, cmd_index, cmd_arg, resp_type, cmd_in,
    output cmd_out, cmd_oe, busy, done, resp_index, resp_data,
    output err_timeout, err_crc, err_index, err_frame
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// SD CMD-line sequencer: sends a 48-bit command frame with CRC7, optionally
// waits for and receives a 48-bit response, checks it, then enforces an NRC
// idle gap. All line activity advances on sd_tick.
// Optional macro SD_CMD_RX_CRC_CHECK_EN enables receive CRC7 checking;
// without it err_crc is constant 0.
module sd_cmd_sequencer #(
  parameter int TIMEOUT_TICKS = 64,
  parameter int NRC_TICKS     = 8
) (
  input logic              clk,
  input logic              reset,
  sd_cmd_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_TX, S_WAIT_RESP, S_RX, S_CHECK, S_GAP
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_TICKS - 1);
  localparam logic [7:0] NRC_LAST     = 8'(NRC_TICKS - 1);

  // CRC7, polynomial x^7 + x^3 + 1, init 0, MSB first over 40 bits.
  function automatic logic [6:0] crc7_40(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [47:0] r_shift;
  logic [46:0] r_rx;     // response bits after the start bit
  logic [5:0]  r_index;
  logic [1:0]  r_type;
  logic        r_cmd_oe;
  logic        r_cmd_out;
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_resp_index;
  logic [31:0] r_resp_data;
  logic        r_err_timeout;
  logic        r_err_crc;
  logic        r_err_index;
  logic        r_err_frame;

  logic [6:0]  w_tx_crc;
  logic        w_crc_bad;

  assign w_tx_crc = crc7_40({2'b01, bus.cmd_index, bus.cmd_arg});

`ifdef SD_CMD_RX_CRC_CHECK_EN
  logic [6:0] w_rx_crc;
  assign w_rx_crc  = crc7_40({1'b0, r_rx[46:8]});
  // Types 1 and 3 carry a real CRC; type 2 (R3) does not.
  assign w_crc_bad = (r_type != 2'd2) && (w_rx_crc != r_rx[7:1]);
`else
  logic w_unused_rx_crc;
  assign w_unused_rx_crc = ^r_rx[7:1];
  assign w_crc_bad       = 1'b0;
`endif

  // Sequencer FSM with registered line drive, status and response outputs.
  // NOTE: every register here, including the frame/response shifters, is
  // cleared by reset so a mid-frame reset leaves no stale state behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_rx          <= '0;
      r_index       <= '0;
      r_type        <= '0;
      r_cmd_oe      <= 1'b0;
      r_cmd_out     <= 1'b1;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_resp_index  <= '0;
      r_resp_data   <= '0;
      r_err_timeout <= 1'b0;
      r_err_crc     <= 1'b0;
      r_err_index   <= 1'b0;
      r_err_frame   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_start) begin
            r_index       <= bus.cmd_index;
            r_type        <= bus.resp_type;
            r_shift       <= {2'b01, bus.cmd_index, bus.cmd_arg, w_tx_crc, 1'b1};
            r_err_timeout <= 1'b0;
            r_err_crc     <= 1'b0;
            r_err_index   <= 1'b0;
            r_err_frame   <= 1'b0;
            r_busy        <= 1'b1;
            r_cnt         <= '0;
            r_state       <= S_TX;
          end
        end
        S_TX: begin
          if (bus.sd_tick) begin
            if (r_cnt == 8'd48) begin
              // Bit 47 has had its full period; release the line.
              r_cmd_oe  <= 1'b0;
              r_cmd_out <= 1'b1;
              r_cnt     <= '0;
              r_state   <= (r_type == 2'd0) ? S_CHECK : S_WAIT_RESP;
            end else begin
              r_cmd_oe  <= 1'b1;
              r_cmd_out <= r_shift[47];
              r_shift   <= {r_shift[46:0], 1'b0};
              r_cnt     <= r_cnt + 8'd1;
            end
          end
        end
        S_WAIT_RESP: begin
          if (bus.sd_tick) begin
            if (!bus.cmd_in) begin
              r_cnt   <= '0;
              r_state <= S_RX;
            end else if (r_cnt == TIMEOUT_LAST) begin
              r_err_timeout <= 1'b1;
              r_cnt         <= '0;
              r_state       <= S_CHECK;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_RX: begin
          if (bus.sd_tick) begin
            r_rx <= {r_rx[45:0], bus.cmd_in};
            if (r_cnt == 8'd46) begin
              r_cnt   <= '0;
              r_state <= S_CHECK;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        S_CHECK: begin
          // No response expected, or timed out: keep previous response.
          if (r_type != 2'd0 && !r_err_timeout) begin
            r_err_frame  <= r_rx[46] | ~r_rx[0];
            r_err_index  <= (r_type != 2'd2) && (r_rx[45:40] != r_index);
            r_err_crc    <= w_crc_bad;
            r_resp_index <= r_rx[45:40];
            r_resp_data  <= r_rx[39:8];
          end
          r_done  <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (bus.sd_tick) begin
            if (r_cnt == NRC_LAST) begin
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output enable drops with reset directly, without waiting for a clock.
  assign bus.cmd_oe      = r_cmd_oe & ~reset;
  assign bus.cmd_out     = r_cmd_out;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.resp_index  = r_resp_index;
  assign bus.resp_data   = r_resp_data;
  assign bus.err_timeout = r_err_timeout;
  assign bus.err_crc     = r_err_crc;
  assign bus.err_index   = r_err_index;
  assign bus.err_frame   = r_err_frame;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed self-checking bench for sd_cmd_sequencer. Ticks are issued one
// at a time by the stimulus; a small monitor records the tick number at
// which done pulses and busy falls.
module tb_sd_cmd_sequencer;
  localparam int TO  = 64;
  localparam int NRC = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_cmd_sequencer_if bus();

  sd_cmd_sequencer #(.TIMEOUT_TICKS(TO), .NRC_TICKS(NRC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int tick_no = 0;
  int done_cnt = 0;
  int done_tick = 0;
  int busy_fall_tick = 0;
  int first_tick = 0;
  int rel_tick = 0;
  int d0;
  logic        prev_busy = 1'b0;
  logic [47:0] tx_frame;
  logic        oe_all;
`ifdef SD_CMD_RX_CRC_CHECK_EN
  localparam logic CRC_EN = 1'b1;
`else
  localparam logic CRC_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record done pulses and busy falls just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_tick = tick_no;
    end
    if (prev_busy && bus.busy === 1'b0) busy_fall_tick = tick_no;
    prev_busy = (bus.busy === 1'b1);
  end

  // Called at a falling edge; one tick-high clock, one quiet clock.
  task automatic pulse_tick();
    bus.sd_tick = 1'b1;
    tick_no++;
    @(negedge clk);
    bus.sd_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    bus.cmd_index = idx;
    bus.cmd_arg   = arg;
    bus.resp_type = rt;
    bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    check("busy_at_accept", bus.busy, 1'b1);
  endtask

  // Capture the 48 transmitted bits, then the release tick.
  task automatic tx_run();
    oe_all = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i == 10) begin
        bus.cmd_start = 1'b1;       // must be ignored while busy
        bus.cmd_index = 6'h3F;
      end
      pulse_tick();
      bus.cmd_start = 1'b0;
      if (i == 0) first_tick = tick_no;
      tx_frame = {tx_frame[46:0], bus.cmd_out};
      oe_all   = oe_all & bus.cmd_oe;
    end
    pulse_tick();
    rel_tick = tick_no;
    check("oe_released", bus.cmd_oe, 1'b0);
    check("out_idle_high", bus.cmd_out, 1'b1);
  endtask

  // One idle tick, then start bit on the second tick after TX end.
  task automatic drive_resp(input logic [47:0] f);
    bus.cmd_in = 1'b1;
    pulse_tick();
    for (int i = 47; i >= 0; i--) begin
      bus.cmd_in = f[i];
      pulse_tick();
    end
    bus.cmd_in = 1'b1;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3 * NRC && bus.busy; n++) pulse_tick();
    check("busy_fall", bus.busy, 1'b0);
    check("nrc_gap", 64'(busy_fall_tick - done_tick), 64'(NRC));
  endtask

  function automatic logic [47:0] frame(input logic tbit, input logic [5:0] idx,
                                        input logic [31:0] data, input logic [6:0] crc,
                                        input logic endb);
    return {1'b0, tbit, idx, data, crc, endb};
  endfunction

  initial begin
    reset         = 1'b1;
    bus.sd_tick   = 1'b0;
    bus.cmd_start = 1'b0;
    bus.cmd_index = '0;
    bus.cmd_arg   = '0;
    bus.resp_type = '0;
    bus.cmd_in    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_oe", bus.cmd_oe, 1'b0);
    check("rst_out", bus.cmd_out, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_resp_index", bus.resp_index, 6'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_errs", {bus.err_timeout, bus.err_crc, bus.err_index, bus.err_frame}, 4'b0000);
    reset = 1'b0;
    @(negedge clk);

    // CMD0, no response: 40 00000000 95 on the line.
    d0 = done_cnt;
    start_cmd(6'd0, 32'h0, 2'd0);
    tx_run();
    check("cmd0_frame", tx_frame, 48'h40_0000_0000_95);
    check("cmd0_oe_frame", oe_all, 1'b1);
    check("cmd0_done_once", done_cnt - d0, 1);
    check("cmd0_done_latency", 64'(done_tick - first_tick), 64'd48);
    wait_idle();

    // CMD55 with a good R1.
    d0 = done_cnt;
    start_cmd(6'd55, 32'h0, 2'd1);
    tx_run();
    check("cmd55_frame", tx_frame, 48'h77_0000_0000_65);
    drive_resp(frame(1'b0, 6'd55, 32'h0, 7'h78, 1'b1));
    check("r1_done", done_cnt - d0, 1);
    check("r1_index", bus.resp_index, 6'd55);
    check("r1_data", bus.resp_data, 32'h0);
    check("r1_errs", {bus.err_timeout, bus.err_crc, bus.err_index, bus.err_frame}, 4'b0000);
    wait_idle();

    // Same response with a corrupted CRC field.
    start_cmd(6'd55, 32'h0, 2'd1);
    tx_run();
    drive_resp(frame(1'b0, 6'd55, 32'h0, 7'h79, 1'b1));
    check("badcrc_err_crc", bus.err_crc, CRC_EN);
    check("badcrc_others", {bus.err_timeout, bus.err_index, bus.err_frame}, 3'b000);
    wait_idle();

    // R3-type: index and CRC fields ignored.
    start_cmd(6'd41, 32'h40FF_8000, 2'd2);
    tx_run();
    drive_resp(frame(1'b0, 6'h3F, 32'hDEAD_BEEF, 7'h7F, 1'b1));
    check("r3_index", bus.resp_index, 6'h3F);
    check("r3_data", bus.resp_data, 32'hDEAD_BEEF);
    check("r3_errs", {bus.err_timeout, bus.err_crc, bus.err_index, bus.err_frame}, 4'b0000);
    wait_idle();

    // Timeout: cmd_in stays high.
    d0 = done_cnt;
    start_cmd(6'd55, 32'h0, 2'd1);
    tx_run();
    for (int n = 0; n < TO + 10 && done_cnt == d0; n++) pulse_tick();
    check("to_latency", 64'(done_tick - rel_tick), 64'(TO));
    check("to_err", bus.err_timeout, 1'b1);
    check("to_other_errs", {bus.err_crc, bus.err_index, bus.err_frame}, 3'b000);
    check("to_keep_index", bus.resp_index, 6'h3F);
    check("to_keep_data", bus.resp_data, 32'hDEAD_BEEF);
    wait_idle();
    check("to_done_once", done_cnt - d0, 1);

    // Wrong index for R1, then the same frame as R3.
    start_cmd(6'd55, 32'h0, 2'd1);
    check("accept_clears_timeout", bus.err_timeout, 1'b0);
    tx_run();
    drive_resp(frame(1'b0, 6'd17, 32'h0, 7'h78, 1'b1));
    check("idx_r1_err", bus.err_index, 1'b1);
    check("idx_r1_resp_index", bus.resp_index, 6'd17);
    wait_idle();
    start_cmd(6'd55, 32'h0, 2'd2);
    tx_run();
    drive_resp(frame(1'b0, 6'd17, 32'h0, 7'h78, 1'b1));
    check("idx_r3_err", bus.err_index, 1'b0);
    wait_idle();

    // Transmission bit set to 1 in the response.
    start_cmd(6'd55, 32'h0, 2'd1);
    tx_run();
    drive_resp(frame(1'b1, 6'd55, 32'h0, 7'h78, 1'b1));
    check("frame_err", bus.err_frame, 1'b1);
    check("frame_idx_ok", bus.err_index, 1'b0);
    wait_idle();

    // Reset in the middle of TX, then an immediate new command.
    start_cmd(6'd17, 32'h1234, 2'd1);
    for (int i = 0; i < 20; i++) pulse_tick();
    check("midtx_oe_before", bus.cmd_oe, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midtx_oe_async", bus.cmd_oe, 1'b0);
    check("midtx_busy", bus.busy, 1'b0);
    check("midtx_out", bus.cmd_out, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    start_cmd(6'd8, 32'h0000_01AA, 2'd1);
    tx_run();
    check("cmd8_frame", tx_frame, 48'h48_0000_01AA_87);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
